// File: rtl/c_add_pkg.sv
// Shared definitions for the two-requester adder arbiter: default latency,
// drain FSM encoding and the requester-id type carried down the tag pipeline.
package c_add_pkg;

  localparam int ADD_LAT_DEF = 2;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/c_rr_arb2.sv
// Two-way round-robin grant. The requester that was not served last wins a
// tie; the last-served register moves only when a grant is actually issued.
module c_rr_arb2
  import c_add_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    en,
  input  logic    req0,
  input  logic    req1,
  output logic    gnt0,
  output logic    gnt1,
  output req_id_t gnt_id
);

  req_id_t last_q;
  req_id_t last_d;

  assign gnt0   = en & req0 & (~req1 | (last_q == REQ1));
  assign gnt1   = en & req1 & (~req0 | (last_q == REQ0));
  assign gnt_id = gnt1 ? REQ1 : REQ0;

  always_comb begin
    last_d = last_q;
    if (gnt0) begin
      last_d = REQ0;
    end else if (gnt1) begin
      last_d = REQ1;
    end
  end

  // Starting with REQ1 as "last served" hands the first tie to requester 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= REQ1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/c_add_arb.sv
// Shares one fixed-latency FP adder between two requesters: arbitrates, tags
// each issued pair with its owner, routes results back and supports draining.
module c_add_arb
  import c_add_pkg::*;
#(
  parameter int ADD_LAT = ADD_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [31:0]      r0_a,
  input  logic [31:0]      r0_b,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [31:0]      r1_a,
  input  logic [31:0]      r1_b,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_r,
  input  logic             add_exception,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [31:0]      rsp_data,
  output logic             rsp_exc,
  input  logic             drain_req,
  output logic             drain_done,
  output logic             busy,
  output logic [CNT_W-1:0] issue_count
);

  localparam int IFW = $clog2(ADD_LAT + 2);

  state_e           state_q;
  logic             drain_done_q;
  logic [31:0]      add_a_q;
  logic [31:0]      add_b_q;
  logic [ADD_LAT-1:0] tag_vld_q;
  req_id_t          tag_id_q [ADD_LAT];
  logic [IFW-1:0]   inflight_q;
  logic [IFW-1:0]   inflight_d;
  logic [CNT_W-1:0] issue_q;
  logic [CNT_W-1:0] issue_d;

  logic    grant_en;
  logic    gnt0;
  logic    gnt1;
  req_id_t gnt_id;
  logic    xfer;
  logic    tail_vld;
  req_id_t tail_id;

  // Grants are suppressed in reset as well so ready stays low until RUN is live.
  assign grant_en = (state_q == ST_RUN) & ~drain_req & ~reset;

  c_rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .en     (grant_en),
    .req0   (r0_valid),
    .req1   (r1_valid),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .gnt_id (gnt_id)
  );

  assign xfer     = gnt0 | gnt1;
  assign tail_vld = tag_vld_q[ADD_LAT-1];
  assign tail_id  = tag_id_q[ADD_LAT-1];

  always_comb begin
    inflight_d = inflight_q;
    if (xfer && !tail_vld) begin
      inflight_d = inflight_q + IFW'(1);
    end else if (!xfer && tail_vld) begin
      inflight_d = inflight_q - IFW'(1);
    end
  end

  assign issue_d = xfer ? issue_q + CNT_W'(1) : issue_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      add_a_q    <= '0;
      add_b_q    <= '0;
      inflight_q <= '0;
      issue_q    <= '0;
    end else begin
      inflight_q <= inflight_d;
      issue_q    <= issue_d;
      if (xfer) begin
        add_a_q <= gnt0 ? r0_a : r1_a;
        add_b_q <= gnt0 ? r0_b : r1_b;
      end
    end
  end

  // Head is loaded at the transfer edge, so the tag reaches the tail in step
  // with the adder result; clearing on reset drops every in-flight response.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ADD_LAT; i++) begin
        tag_vld_q[i] <= 1'b0;
        tag_id_q[i]  <= REQ0;
      end
    end else begin
      tag_vld_q[0] <= xfer;
      tag_id_q[0]  <= gnt_id;
      for (int i = 1; i < ADD_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      drain_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (drain_req) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (inflight_q == '0) begin
            state_q      <= ST_DONE;
            drain_done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!drain_req) begin
            state_q      <= ST_RUN;
            drain_done_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_RUN;
          drain_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign r0_ready    = gnt0;
  assign r1_ready    = gnt1;
  assign add_a       = add_a_q;
  assign add_b       = add_b_q;
  assign rsp0_valid  = tail_vld & (tail_id == REQ0);
  assign rsp1_valid  = tail_vld & (tail_id == REQ1);
  assign rsp_data    = add_r;
  assign rsp_exc     = add_exception;
  assign drain_done  = drain_done_q;
  assign busy        = (inflight_q != '0);
  assign issue_count = issue_q;

endmodule

// File: tb/tb_c_add_arb.sv
// Directed bench for c_add_arb: handshake, round-robin order, response
// latency, drain sequence, reset flush, counter wrap and exception routing.
module tb_c_add_arb;

  logic        clk;
  logic        reset;
  logic        r0_valid;
  logic        r0_ready;
  logic [31:0] r0_a;
  logic [31:0] r0_b;
  logic        r1_valid;
  logic        r1_ready;
  logic [31:0] r1_a;
  logic [31:0] r1_b;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_r;
  logic        add_exception;
  logic        rsp0_valid;
  logic        rsp1_valid;
  logic [31:0] rsp_data;
  logic        rsp_exc;
  logic        drain_req;
  logic        drain_done;
  logic        busy;
  logic [15:0] issue_count;

  int total;
  int bad;

  c_add_arb #(.ADD_LAT(2), .CNT_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .r0_valid      (r0_valid),
    .r0_ready      (r0_ready),
    .r0_a          (r0_a),
    .r0_b          (r0_b),
    .r1_valid      (r1_valid),
    .r1_ready      (r1_ready),
    .r1_a          (r1_a),
    .r1_b          (r1_b),
    .add_a         (add_a),
    .add_b         (add_b),
    .add_r         (add_r),
    .add_exception (add_exception),
    .rsp0_valid    (rsp0_valid),
    .rsp1_valid    (rsp1_valid),
    .rsp_data      (rsp_data),
    .rsp_exc       (rsp_exc),
    .drain_req     (drain_req),
    .drain_done    (drain_done),
    .busy          (busy),
    .issue_count   (issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                               input logic drain);
    r0_valid  = v0;
    r0_a      = a0;
    r0_b      = b0;
    r1_valid  = v1;
    r1_a      = a1;
    r1_b      = b1;
    drain_req = drain;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    reset         = 1'b1;
    add_r         = '0;
    add_exception = 1'b0;

    // Reset state, with both requesters pushing to prove ready is held low
    applyStimulus(1, 32'h1, 32'h2, 1, 32'h3, 32'h4, 0);
    tick();
    checkOutput("rst_r0_ready", r0_ready, 0);
    checkOutput("rst_r1_ready", r1_ready, 0);
    checkOutput("rst_rsp0", rsp0_valid, 0);
    checkOutput("rst_rsp1", rsp1_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_drain_done", drain_done, 0);
    checkOutput("rst_issue", issue_count, 0);
    checkOutput("rst_add_a", add_a, 0);
    checkOutput("rst_add_b", add_b, 0);
    tick();
    reset = 1'b0;

    // Single r0 operation: 1.0 + 2.0
    $display("[TB] single request");
    applyStimulus(1, 32'h3F800000, 32'h40000000, 0, 0, 0, 0);
    checkOutput("single_r0_ready", r0_ready, 1);
    checkOutput("single_r1_ready", r1_ready, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("single_add_a", add_a, 32'h3F800000);
    checkOutput("single_add_b", add_b, 32'h40000000);
    checkOutput("single_issue", issue_count, 1);
    checkOutput("single_busy", busy, 1);
    checkOutput("single_rsp0_early", rsp0_valid, 0);
    checkOutput("single_ready_drop", r0_ready, 0);
    tick();
    add_r = 32'h40400000;
    #1;
    checkOutput("single_rsp0", rsp0_valid, 1);
    checkOutput("single_rsp1", rsp1_valid, 0);
    checkOutput("single_rsp_data", rsp_data, 32'h40400000);
    tick();
    checkOutput("single_rsp0_gone", rsp0_valid, 0);
    checkOutput("single_busy_gone", busy, 0);

    // Both requesters valid for 6 cycles: grants and responses alternate 0,1,...
    $display("[TB] round robin");
    doReset();
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        applyStimulus(1, 32'(i), 32'h0, 1, 32'(100 + i), 32'h0, 0);
        checkOutput("rr_r0_ready", r0_ready, (i % 2) == 0);
        checkOutput("rr_r1_ready", r1_ready, (i % 2) == 1);
      end else begin
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
      end
      if (i >= 2) begin
        checkOutput("rr_rsp0", rsp0_valid, ((i - 2) % 2) == 0);
        checkOutput("rr_rsp1", rsp1_valid, ((i - 2) % 2) == 1);
      end
      if (i == 2) begin
        checkOutput("rr_add_a", add_a, 32'd101);
      end
      tick();
    end
    checkOutput("rr_issue", issue_count, 6);
    checkOutput("rr_busy", busy, 0);

    // Three back-to-back transfers, then drain
    $display("[TB] drain");
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'(i), 32'h0, 0, 0, 0, 0);
      checkOutput("drn_r0_ready", r0_ready, 1);
      tick();
    end
    applyStimulus(1, 0, 0, 1, 0, 0, 1);
    checkOutput("drn_s3_r0_ready", r0_ready, 0);
    checkOutput("drn_s3_r1_ready", r1_ready, 0);
    checkOutput("drn_s3_busy", busy, 1);
    checkOutput("drn_s3_rsp0", rsp0_valid, 1);
    tick();
    checkOutput("drn_s4_r0_ready", r0_ready, 0);
    checkOutput("drn_s4_r1_ready", r1_ready, 0);
    checkOutput("drn_s4_busy", busy, 1);
    checkOutput("drn_s4_rsp0", rsp0_valid, 1);
    checkOutput("drn_s4_done", drain_done, 0);
    tick();
    checkOutput("drn_s5_busy", busy, 0);
    checkOutput("drn_s5_rsp0", rsp0_valid, 0);
    checkOutput("drn_s5_done", drain_done, 0);
    checkOutput("drn_s5_issue", issue_count, 3);
    tick();
    checkOutput("drn_s6_done", drain_done, 1);
    checkOutput("drn_s6_r0_ready", r0_ready, 0);
    tick();
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    checkOutput("drn_s7_done", drain_done, 1);
    checkOutput("drn_s7_r0_ready", r0_ready, 0);
    checkOutput("drn_s7_r1_ready", r1_ready, 0);
    tick();
    checkOutput("drn_s8_done", drain_done, 0);
    checkOutput("drn_s8_r1_ready", r1_ready, 1);
    checkOutput("drn_s8_r0_ready", r0_ready, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();

    // Reset with two operations in flight
    $display("[TB] reset flush");
    doReset();
    applyStimulus(1, 32'h11, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 32'h22, 0, 0);
    checkOutput("flush_r1_ready", r1_ready, 1);
    tick();
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("flush_busy_pre", busy, 1);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("flush_rsp0_a", rsp0_valid, 0);
    checkOutput("flush_rsp1_a", rsp1_valid, 0);
    checkOutput("flush_busy", busy, 0);
    checkOutput("flush_issue", issue_count, 0);
    tick();
    checkOutput("flush_rsp0_b", rsp0_valid, 0);
    checkOutput("flush_rsp1_b", rsp1_valid, 0);
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    checkOutput("flush_next_r0", r0_ready, 1);
    checkOutput("flush_next_r1", r1_ready, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Exception flag routed with an r1 result
    $display("[TB] exception");
    doReset();
    applyStimulus(0, 0, 0, 1, 32'h7F800000, 32'hFF800000, 0);
    checkOutput("exc_r1_ready", r1_ready, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    add_exception = 1'b1;
    add_r         = 32'h7FC00000;
    #1;
    checkOutput("exc_rsp1", rsp1_valid, 1);
    checkOutput("exc_rsp0", rsp0_valid, 0);
    checkOutput("exc_flag", rsp_exc, 1);
    checkOutput("exc_data", rsp_data, 32'h7FC00000);
    tick();
    add_exception = 1'b0;
    #1;
    checkOutput("exc_rsp1_gone", rsp1_valid, 0);
    checkOutput("exc_flag_gone", rsp_exc, 0);

    // issue_count wrap: 0xFFFF transfers, then one more
    $display("[TB] issue_count wrap");
    doReset();
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 65535; i++) begin
      tick();
    end
    checkOutput("wrap_full", issue_count, 16'hFFFF);
    tick();
    checkOutput("wrap_zero", issue_count, 16'h0000);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
